// File: rtl/pa_pkg.sv
// Shared defaults, functional-unit type encoding and width helper for the
// register-read pipeline stage.
package pa_pkg;

  localparam int LANES_DEF    = 2;
  localparam int DATA_W_DEF   = 16;
  localparam int NREGS_DEF    = 32;
  localparam int OPC_W_DEF    = 7;
  localparam int WB_PORTS_DEF = 4;
  localparam int FTYPE_W      = 2;

  typedef enum logic [FTYPE_W-1:0] {
    FT_INT    = 2'd0,
    FT_MEM    = 2'd1,
    FT_BRANCH = 2'd2,
    FT_SYS    = 2'd3
  } ftype_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Register array with prioritised writeback ports and per-read-port bypass;
// rd_hit flags a read that was satisfied from a writeback port this cycle.
module reg_bank
  import pa_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int ADDR_W   = clog2(NREGS),
  parameter int WB_PORTS = WB_PORTS_DEF,
  parameter int RD_PORTS = 2 * LANES_DEF
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic [WB_PORTS-1:0]          wb_en,
  input  logic [WB_PORTS*ADDR_W-1:0]   wb_addr,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_hit
);

  logic [DATA_W-1:0]   mem [NREGS];
  logic [WB_PORTS-1:0] wb_ok;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NREGS);
  endfunction

  // Out-of-range writeback addresses only exist when NREGS is not a power of 2.
  always_comb begin
    wb_ok = '0;
    for (int unsigned p = 0; p < WB_PORTS; p++)
      wb_ok[p] = wb_en[p] && in_range(wb_addr[p*ADDR_W +: ADDR_W]);
  end

  // Ascending port order: the last matching non-blocking write is the one kept.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int unsigned i = 0; i < NREGS; i++)
        mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++)
        for (int unsigned p = 0; p < WB_PORTS; p++)
          if (wb_ok[p] && wb_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(i))
            mem[i] <= wb_data[p*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = '0;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      if (in_range(rd_addr[r*ADDR_W +: ADDR_W]))
        rd_data[r*DATA_W +: DATA_W] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
      for (int unsigned p = 0; p < WB_PORTS; p++) begin
        if (wb_ok[p] && wb_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W]) begin
          rd_hit[r]                   = 1'b1;
          rd_data[r*DATA_W +: DATA_W] = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: captures a decoded bundle, sources operands
// from the register bank and holds them, kept fresh, while execute stalls.
module reg_read_stage
  import pa_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int OPC_W    = OPC_W_DEF,
  parameter int WB_PORTS = WB_PORTS_DEF
) (
  input  logic                              clock_i,
  input  logic                              reset_i,
  input  logic [LANES-1:0]                  valid_i,
  output logic                              ready_o,
  input  logic [LANES-1:0]                  pread_i,
  input  logic [LANES-1:0]                  sread_i,
  input  logic [LANES-1:0]                  pwrite_i,
  input  logic [LANES*OPC_W-1:0]            opcode_i,
  input  logic [LANES*FTYPE_W-1:0]          ftype_i,
  input  logic [LANES*clog2(NREGS)-1:0]     prim_i,
  input  logic [LANES*DATA_W-1:0]           sec_i,
  output logic [LANES-1:0]                  valid_o,
  input  logic                              exec_ready_i,
  output logic [LANES-1:0]                  wb_o,
  output logic [LANES*OPC_W-1:0]            opcode_o,
  output logic [LANES*FTYPE_W-1:0]          ftype_o,
  output logic [LANES*clog2(NREGS)-1:0]     wbaddr_o,
  output logic [LANES*DATA_W-1:0]           prim_o,
  output logic [LANES*DATA_W-1:0]           sec_o,
  input  logic [WB_PORTS-1:0]               wb_en_i,
  input  logic [WB_PORTS*clog2(NREGS)-1:0]  wb_addr_i,
  input  logic [WB_PORTS*DATA_W-1:0]        wb_data_i
);

  localparam int ADDR_W   = clog2(NREGS);
  localparam int RD_PORTS = 2 * LANES;

  logic                         stall;
  logic [LANES-1:0]             pread_q;
  logic [LANES-1:0]             sread_q;
  logic [LANES*ADDR_W-1:0]      sec_addr_q;
  logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;
  logic [RD_PORTS-1:0]          rd_hit;

  assign stall   = (|valid_o) && !exec_ready_i;
  assign ready_o = !stall;

  // Read ports look at the incoming bundle when accepting and at the held
  // addresses while stalled, so the same bypass path serves capture and refresh.
  always_comb begin
    rd_addr = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_addr[k*ADDR_W +: ADDR_W] = stall ? wbaddr_o[k*ADDR_W +: ADDR_W]
                                          : prim_i[k*ADDR_W +: ADDR_W];
      rd_addr[(LANES+k)*ADDR_W +: ADDR_W] = stall ? sec_addr_q[k*ADDR_W +: ADDR_W]
                                                  : sec_i[k*DATA_W +: ADDR_W];
    end
  end

  reg_bank #(
    .DATA_W   (DATA_W),
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .WB_PORTS (WB_PORTS),
    .RD_PORTS (RD_PORTS)
  ) u_bank (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .wb_en   (wb_en_i),
    .wb_addr (wb_addr_i),
    .wb_data (wb_data_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_hit  (rd_hit)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_o    <= '0;
      wb_o       <= '0;
      opcode_o   <= '0;
      ftype_o    <= '0;
      wbaddr_o   <= '0;
      prim_o     <= '0;
      sec_o      <= '0;
      pread_q    <= '0;
      sread_q    <= '0;
      sec_addr_q <= '0;
    end else if (!stall) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        valid_o[k] <= valid_i[k];
        if (valid_i[k]) begin
          wb_o[k]                        <= pwrite_i[k];
          pread_q[k]                     <= pread_i[k];
          sread_q[k]                     <= sread_i[k];
          opcode_o[k*OPC_W +: OPC_W]     <= opcode_i[k*OPC_W +: OPC_W];
          ftype_o[k*FTYPE_W +: FTYPE_W]  <= ftype_i[k*FTYPE_W +: FTYPE_W];
          wbaddr_o[k*ADDR_W +: ADDR_W]   <= prim_i[k*ADDR_W +: ADDR_W];
          sec_addr_q[k*ADDR_W +: ADDR_W] <= sec_i[k*DATA_W +: ADDR_W];
          prim_o[k*DATA_W +: DATA_W]     <= pread_i[k] ? rd_data[k*DATA_W +: DATA_W]
                                                       : DATA_W'(prim_i[k*ADDR_W +: ADDR_W]);
          sec_o[k*DATA_W +: DATA_W]      <= sread_i[k] ? rd_data[(LANES+k)*DATA_W +: DATA_W]
                                                       : sec_i[k*DATA_W +: DATA_W];
        end
      end
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (valid_o[k] && pread_q[k] && rd_hit[k])
          prim_o[k*DATA_W +: DATA_W] <= rd_data[k*DATA_W +: DATA_W];
        if (valid_o[k] && sread_q[k] && rd_hit[LANES+k])
          sec_o[k*DATA_W +: DATA_W] <= rd_data[(LANES+k)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Bench for reg_read_stage: directed scenarios with literal expectations plus
// a behavioural register-file model compared against the outputs every cycle.
module tb_reg_read_stage;
  import pa_pkg::*;

  localparam int LANES = 2, DATA_W = 16, NREGS = 32, OPC_W = 7, WB_PORTS = 4;
  localparam int ADDR_W = 5;

  logic clk, rst_n, ready_o, exec_ready;
  logic [LANES-1:0] valid_i, pread_i, sread_i, pwrite_i, valid_o, wb_o;
  logic [LANES*OPC_W-1:0]    opcode_i, opcode_o;
  logic [LANES*2-1:0]        ftype_i, ftype_o;
  logic [LANES*ADDR_W-1:0]   prim_i, wbaddr_o;
  logic [LANES*DATA_W-1:0]   sec_i, prim_o, sec_o;
  logic [WB_PORTS-1:0]       wb_en;
  logic [WB_PORTS*ADDR_W-1:0] wb_addr;
  logic [WB_PORTS*DATA_W-1:0] wb_data;

  reg_read_stage #(
    .LANES(LANES), .DATA_W(DATA_W), .NREGS(NREGS), .OPC_W(OPC_W), .WB_PORTS(WB_PORTS)
  ) dut (
    .clock_i(clk), .reset_i(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .pread_i(pread_i), .sread_i(sread_i), .pwrite_i(pwrite_i),
    .opcode_i(opcode_i), .ftype_i(ftype_i), .prim_i(prim_i), .sec_i(sec_i),
    .valid_o(valid_o), .exec_ready_i(exec_ready), .wb_o(wb_o),
    .opcode_o(opcode_o), .ftype_o(ftype_o), .wbaddr_o(wbaddr_o),
    .prim_o(prim_o), .sec_o(sec_o),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem [NREGS];
  logic              m_valid [LANES];
  logic              m_wb [LANES], m_pr [LANES], m_sr [LANES];
  logic [OPC_W-1:0]  m_opc [LANES];
  logic [1:0]        m_ft [LANES];
  logic [ADDR_W-1:0] m_pa [LANES], m_sa [LANES];
  logic [DATA_W-1:0] m_prim [LANES], m_sec [LANES];
  bit                m_stall;

  function automatic int wb_a(input int p);
    logic [ADDR_W-1:0] a;
    a = wb_addr[p*ADDR_W +: ADDR_W];
    return int'(a);
  endfunction

  function automatic logic [DATA_W-1:0] model_read(input int a, output bit hit);
    logic [DATA_W-1:0] v;
    hit = 0;
    v = (a < NREGS) ? m_mem[a] : '0;
    for (int p = 0; p < WB_PORTS; p++)
      if (wb_en[p] && wb_a(p) == a && wb_a(p) < NREGS) begin
        hit = 1;
        v = wb_data[p*DATA_W +: DATA_W];
      end
    return v;
  endfunction

  function automatic bit model_any_valid();
    bit v;
    v = 0;
    for (int k = 0; k < LANES; k++) v = v | m_valid[k];
    return v;
  endfunction

  initial begin
    bit h;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
        for (int k = 0; k < LANES; k++) begin
          m_valid[k] = 0; m_wb[k] = 0; m_pr[k] = 0; m_sr[k] = 0; m_opc[k] = '0;
          m_ft[k] = '0; m_pa[k] = '0; m_sa[k] = '0; m_prim[k] = '0; m_sec[k] = '0;
        end
      end else begin
        m_stall = model_any_valid() && !exec_ready;
        for (int k = 0; k < LANES; k++) begin
          if (!m_stall) begin
            m_valid[k] = valid_i[k];
            if (valid_i[k]) begin
              m_wb[k]  = pwrite_i[k];
              m_pr[k]  = pread_i[k];
              m_sr[k]  = sread_i[k];
              m_opc[k] = opcode_i[k*OPC_W +: OPC_W];
              m_ft[k]  = ftype_i[k*2 +: 2];
              m_pa[k]  = prim_i[k*ADDR_W +: ADDR_W];
              m_sa[k]  = sec_i[k*DATA_W +: ADDR_W];
              m_prim[k] = pread_i[k] ? model_read(int'(m_pa[k]), h) : DATA_W'(m_pa[k]);
              m_sec[k]  = sread_i[k] ? model_read(int'(m_sa[k]), h) : sec_i[k*DATA_W +: DATA_W];
            end
          end else if (m_valid[k]) begin
            d = model_read(int'(m_pa[k]), h);
            if (m_pr[k] && h) m_prim[k] = d;
            d = model_read(int'(m_sa[k]), h);
            if (m_sr[k] && h) m_sec[k] = d;
          end
        end
        for (int p = 0; p < WB_PORTS; p++)
          if (wb_en[p] && wb_a(p) < NREGS) m_mem[wb_a(p)] = wb_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("ready", 32'(ready_o), 32'(!model_any_valid() || exec_ready));
        for (int k = 0; k < LANES; k++) begin
          check("m_valid", 32'(valid_o[k]), 32'(m_valid[k]));
          if (m_valid[k]) begin
            check("m_prim",   32'(prim_o[k*DATA_W +: DATA_W]), 32'(m_prim[k]));
            check("m_sec",    32'(sec_o[k*DATA_W +: DATA_W]),  32'(m_sec[k]));
            check("m_opcode", 32'(opcode_o[k*OPC_W +: OPC_W]), 32'(m_opc[k]));
            check("m_ftype",  32'(ftype_o[k*2 +: 2]),          32'(m_ft[k]));
            check("m_wbaddr", 32'(wbaddr_o[k*ADDR_W +: ADDR_W]), 32'(m_pa[k]));
            check("m_wb",     32'(wb_o[k]),                    32'(m_wb[k]));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    valid_i = '0; pread_i = '0; sread_i = '0; pwrite_i = '0; wb_en = '0;
  endtask

  task automatic lane(input int k, input logic pr, input logic sr, input logic pw,
                      input logic [OPC_W-1:0] opc, input logic [1:0] ft,
                      input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] sv);
    valid_i[k] = 1'b1; pread_i[k] = pr; sread_i[k] = sr; pwrite_i[k] = pw;
    opcode_i[k*OPC_W +: OPC_W] = opc;
    ftype_i[k*2 +: 2] = ft;
    prim_i[k*ADDR_W +: ADDR_W] = pa;
    sec_i[k*DATA_W +: DATA_W] = sv;
  endtask

  task automatic wb(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_en[p] = 1'b1;
    wb_addr[p*ADDR_W +: ADDR_W] = a;
    wb_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] prim_of(input int k);
    return 32'(prim_o[k*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [31:0] sec_of(input int k);
    return 32'(sec_o[k*DATA_W +: DATA_W]);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [DATA_W-1:0] sv;
    rst_n = 1'b0; exec_ready = 1'b1;
    opcode_i = '0; ftype_i = '0; prim_i = '0; sec_i = '0; wb_addr = '0; wb_data = '0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_prim", 32'(prim_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h1);
    #1 rst_n = 1'b1;
    step();
    check("release_ready", 32'(ready_o), 32'h1);

    // r5 written, then read as primary on lane 0
    wb(0, 5'd5, 16'h1234);
    step();
    idle();
    lane(0, 1, 0, 1, 7'h11, 2'd1, 5'd5, 16'h0);
    step();
    check("r5_valid0", 32'(valid_o[0]), 32'h1);
    check("r5_prim0", prim_of(0), 32'h1234);
    check("r5_wbaddr0", 32'(wbaddr_o[ADDR_W-1:0]), 32'd5);
    idle();
    step();
    check("drain_valid", 32'(valid_o), 32'h0);

    // two ports write r7 in the same cycle as the read; port 3 wins
    wb(1, 5'd7, 16'hAAAA);
    wb(3, 5'd7, 16'h5555);
    lane(1, 0, 1, 0, 7'h22, 2'd2, 5'd0, 16'd7);
    step();
    check("prio_bypass_sec1", sec_of(1), 32'h5555);
    idle();
    lane(0, 1, 0, 0, 7'h23, 2'd0, 5'd7, 16'h0);
    lane(1, 0, 1, 0, 7'h24, 2'd0, 5'd0, 16'd7);
    step();
    check("prio_array_prim0", prim_of(0), 32'h5555);
    check("prio_array_sec1", sec_of(1), 32'h5555);

    // literal operands
    idle();
    lane(0, 0, 0, 0, 7'h30, 2'd3, 5'd9, 16'h0);
    lane(1, 0, 0, 0, 7'h31, 2'd3, 5'd0, 16'h00FF);
    step();
    check("lit_prim0", prim_of(0), 32'h0009);
    check("lit_sec1", sec_of(1), 32'h00FF);

    // both lanes see the bypassed value, lane0's pwrite does not forward
    idle();
    wb(2, 5'd5, 16'hCAFE);
    lane(0, 1, 0, 1, 7'h32, 2'd0, 5'd5, 16'h0);
    lane(1, 0, 1, 0, 7'h33, 2'd0, 5'd0, 16'd5);
    step();
    check("byp_prim0", prim_of(0), 32'hCAFE);
    check("byp_sec1", sec_of(1), 32'hCAFE);

    // stall with refresh of a sourced operand
    idle();
    lane(0, 1, 0, 0, 7'h2A, 2'd1, 5'd3, 16'h0);
    step();
    check("r3_before", prim_of(0), 32'h0);
    idle();
    exec_ready = 1'b0;
    lane(1, 1, 0, 0, 7'h55, 2'd0, 5'd5, 16'h0);
    #1;
    check("stall_ready", 32'(ready_o), 32'h0);
    wb(0, 5'd3, 16'hBEEF);
    step();
    check("refresh_prim0", prim_of(0), 32'hBEEF);
    check("refresh_opcode0", 32'(opcode_o[OPC_W-1:0]), 32'h2A);
    check("stall_reject", 32'(valid_o), 32'h1);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(valid_o), 32'h1);
      check("hold_ready", 32'(ready_o), 32'h0);
    end
    exec_ready = 1'b1;
    #1;
    check("release_ready_comb", 32'(ready_o), 32'h1);
    step();
    check("release_valid", 32'(valid_o), 32'h0);
    check("release_ready_after", 32'(ready_o), 32'h1);

    // a literal operand is not refreshed by a matching writeback
    lane(0, 0, 0, 0, 7'h40, 2'd0, 5'd3, 16'h0);
    step();
    idle();
    exec_ready = 1'b0;
    wb(1, 5'd3, 16'h1111);
    step();
    check("no_refresh_literal", prim_of(0), 32'h0003);

    // reset asserted mid-stall, between edges
    idle();
    exec_ready = 1'b1;
    lane(0, 1, 0, 0, 7'h60, 2'd2, 5'd5, 16'h0);
    step();
    idle();
    exec_ready = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(valid_o), 32'h0);
    check("async_prim", 32'(prim_o), 32'h0);
    check("async_opcode", 32'(opcode_o), 32'h0);
    lane(0, 1, 0, 0, 7'h61, 2'd0, 5'd5, 16'h0);
    step();
    check("rst_no_accept", 32'(valid_o), 32'h0);
    idle();
    #1 rst_n = 1'b1;
    exec_ready = 1'b1;
    lane(0, 1, 0, 0, 7'h62, 2'd0, 5'd5, 16'h0);
    lane(1, 0, 1, 0, 7'h63, 2'd0, 5'd0, 16'd7);
    step();
    check("post_rst_r5", prim_of(0), 32'h0);
    check("post_rst_r7", sec_of(1), 32'h0);
    check("post_rst_valid", 32'(valid_o), 32'h3);

    // mixed traffic checked by the model
    for (int c = 0; c < 80; c++) begin
      idle();
      exec_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < LANES; k++) begin
        if ($urandom_range(0, 1) != 0) begin
          sv = 16'($urandom);
          sv = (sv & ~16'h001F) | 16'($urandom_range(0, 7));
          lane(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               7'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), sv);
        end
      end
      for (int p = 0; p < WB_PORTS; p++)
        if ($urandom_range(0, 2) == 0) wb(p, 5'($urandom_range(0, 7)), 16'($urandom));
      step();
    end
    idle();
    exec_ready = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
